// File: rtl/mini_core_pkg.sv
// Shared types and constants for the mini RV32I core: control states, trap causes,
// opcodes and a small instruction-format helper.
package mini_core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_TRAP      = 3'd4
  } state_t;

  localparam logic [1:0]  TRAP_NONE     = 2'b00;
  localparam logic [1:0]  TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0]  TRAP_FETCH_TO = 2'b10;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  localparam logic [4:0]  OP_ALU_IMM    = 5'b00100;
  localparam logic [4:0]  OP_ALU_REG    = 5'b01100;

  // 32-bit (non-compressed) encodings always carry 2'b11 in the low bits.
  function automatic logic is_rv32_word(input logic [31:0] w);
    return w[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/mini_fetch_timer.sv
// Saturating wait counter for the fetch handshake; flags the cycle on which the
// LIMIT-th consecutive unanswered request cycle occurs.
module mini_fetch_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_timeout
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
  end

  assign o_timeout = i_en && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mini_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with sticky trap.
// Optional retire counter output enabled by defining MINI_CTRL_RETIRE_CNT_EN.
module mini_ctrl_fsm
  import mini_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_isALU,
  input  logic        dec_writeBackEn,
  input  logic [4:0]  dec_rd,
  output logic        rf_rd_en,
  output logic        alu_en,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  trap_cause
`ifdef MINI_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [1:0]  r_cause;
  logic        w_accept;
  logic        w_wait;
  logic        w_timeout;

  // r_req is only ever set while in FETCH, so it alone qualifies the handshake.
  assign w_accept = r_req &  imem_ready;
  assign w_wait   = r_req & ~imem_ready;

  mini_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_fetch_timer (
    .clk       (clk),
    .resetn    (resetn),
    .i_en      (w_wait),
    .i_clr     (w_accept),
    .o_timeout (w_timeout)
  );

`ifdef MINI_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retire;
  assign retire_cnt = r_retire;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_FETCH;
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_cause <= TRAP_NONE;
`ifdef MINI_CTRL_RETIRE_CNT_EN
      r_retire <= '0;
`endif
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_req <= 1'b1;
          if (w_accept) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_state <= ST_DECODE;
          end else if (w_timeout) begin
            r_cause <= TRAP_FETCH_TO;
            r_req   <= 1'b0;
            r_state <= ST_TRAP;
          end
        end
        ST_DECODE: begin
          if (!is_rv32_word(r_instr) || !dec_isALU) begin
            r_cause <= TRAP_ILLEGAL;
            r_state <= ST_TRAP;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: r_state <= ST_WRITEBACK;
        ST_WRITEBACK: begin
          r_pc    <= r_pc + 32'd4;
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
`ifdef MINI_CTRL_RETIRE_CNT_EN
          r_retire <= r_retire + 32'd1;
`endif
        end
        ST_TRAP: r_req <= 1'b0;
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_TRAP;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign instr      = r_instr;
  assign trap_cause = r_cause;
  assign halted     = (r_state == ST_TRAP);
  assign rf_rd_en   = (r_state == ST_DECODE);
  assign alu_en     = (r_state == ST_EXECUTE);
  assign rf_we      = (r_state == ST_WRITEBACK) && dec_writeBackEn && (dec_rd != 5'd0);

endmodule

// File: doc/mini_ctrl_fsm.md
Name: mini_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the mini RV32I core.
- Owns the PC and fetches instructions over a req/ready memory handshake.
- Holds the instruction stable for the combinational mini decoder, then steps register-file read, ALU execute and write-back one state per cycle.
- Halts on an illegal or unsupported opcode, or on a fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 15, max cycles imem_req may wait for imem_ready before a fault (1..255).

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  32  fetch address (= pc).
- imem_ready  in  1  memory accepts request; imem_rdata valid same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction to decoder.
- dec_isALU  in  1  decoder isALU.
- dec_writeBackEn  in  1  decoder writeBackEn.
- dec_rd  in  5  decoder rd.
- rf_rd_en  out  1  register-file read strobe.
- alu_en  out  1  ALU operand/result capture strobe.
- rf_we  out  1  register-file write enable.
- pc  out  32  current program counter.
- halted  out  1  sticky trap indication.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout.

Behaviour:
- Reset (async, resetn=0): state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), halted=0, trap_cause=00, timeout counter=0, imem_req=0. All strobes are 0 while resetn=0.
- First imem_req is raised in the first cycle after resetn deasserts.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP. One-hot or binary encoding; illegal encodings recover to TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready: instr<=imem_rdata, counter<=0, next DECODE.
  - Else counter++. When counter reaches FETCH_TIMEOUT without ready: trap_cause<=10, next TRAP.
  - imem_addr must not change while imem_req=1.
- DECODE:
  - rf_rd_en=1.
  - If instr[1:0]!=2'b11 or dec_isALU=0: trap_cause<=01, next TRAP (no writeback, pc unchanged).
  - Else next EXECUTE.
- EXECUTE: alu_en=1 for exactly one cycle; next WRITEBACK.
- WRITEBACK:
  - rf_we = dec_writeBackEn & (dec_rd!=0). Writes to x0 are suppressed.
  - pc<=pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Next FETCH.
- TRAP: halted=1 and all strobes 0. Sticky until reset; imem_ready is ignored.
- Throughput: zero-wait memory gives 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK). Each wait cycle adds 1.
- Strobe exclusivity: rf_rd_en, alu_en and rf_we are registered-state decodes; at most one is high in any cycle.
- imem_ready outside FETCH is ignored.
- Reset mid-operation: any state returns to FETCH immediately. A pending request is dropped with no partial writeback.
- instr holds its value in all states except the FETCH accept cycle.

Optional Feature:
- Macro: MINI_CTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt [31:0], reset to 0.
  - Increments by 1 on each WRITEBACK cycle and wraps at 2^32.
  - Not incremented on trap.
- When undefined: port and counter are absent, with identical control behaviour.

Decomposition:
- Shared package mini_core_pkg holds:
  - state encoding constants (ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_TRAP);
  - trap-cause codes (TRAP_NONE, TRAP_ILLEGAL, TRAP_FETCH_TO);
  - NOP_INSTR = 32'h0000_0013;
  - opcode constants OP_ALU_IMM = 5'b00100, OP_ALU_REG = 5'b01100.
- One natural sub-module: mini_fetch_timer (saturating wait counter with timeout flag), instantiated for the FETCH state.

Test Plan:
- Reset, then zero-wait fetch of 32'h0010_0093 (addi x1,x0,1) → imem_addr=0; rf_rd_en, alu_en, rf_we each pulse once on cycles 2, 3, 4; pc=4 in cycle 5.
- imem_ready delayed 3 cycles → imem_req held high with imem_addr stable for 4 cycles; instruction completes in 7 cycles.
- Fetch 32'h0000_0063 (branch, dec_isALU=0) → TRAP entered after DECODE; halted=1, trap_cause=01, rf_we never asserted, pc unchanged.
- imem_ready held low → after FETCH_TIMEOUT=15 cycles, trap_cause=10 and halted=1; later imem_ready pulses are ignored.
- add with rd=0 (32'h0020_8033), dec_writeBackEn=1 → rf_we=0 in WRITEBACK; pc still advances by 4.
- RESET_PC=32'hFFFF_FFFC, one instruction executed → pc wraps to 0. Reset asserted mid-EXECUTE → immediate FETCH at RESET_PC. With MINI_CTRL_RETIRE_CNT_EN, retire_cnt=1 before reset and 0 after.
